// File: rtl/extbus_xseq_if.sv
// ============================================================================
// Module      : extbus_xseq_if
// Description : X-port and external-memory bus bundle for the transfer
//               sequencer (master = sequencer, slave = regfile/memory side).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface extbus_xseq_if #(
    parameter int AW = 20
);
    logic [1:0]    x_addr;
    logic          x_en;
    logic          x_we;
    logic [71:0]   x_wdata;
    logic [71:0]   x_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [71:0]   mem_wdata;
    logic [71:0]   mem_rdata;
    logic          mem_ack;

    modport master (
        output x_addr, x_en, x_we, x_wdata,
        input  x_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  x_addr, x_en, x_we, x_wdata,
        output x_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

`default_nettype wire

// File: rtl/extbus_xseq.sv
// ============================================================================
// Module      : extbus_xseq
// Description : Moves one 72-bit word between a bus-file slot (X port) and
//               external memory with a bounded request/acknowledge wait.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module extbus_xseq #(
    parameter int AW      = 20,
    parameter int TIMEOUT = 255
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    input  wire logic          start,
    input  wire logic          cmd_we,
    input  wire logic [1:0]    cmd_slot,
    input  wire logic [AW-1:0] cmd_addr,
    output logic               busy,
    output logic               done,
    output logic               err,
    extbus_xseq_if.master      bus
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_fetch = 3'd1;
    localparam logic [2:0] c_st_latch = 3'd2;
    localparam logic [2:0] c_st_req   = 3'd3;
    localparam logic [2:0] c_st_store = 3'd4;
    localparam logic [2:0] c_st_done  = 3'd5;

    localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic          r_we;
    logic [1:0]    r_slot;
    logic [AW-1:0] r_addr;
    logic [71:0]   r_wdata;
    logic [71:0]   r_rdata;
    logic [7:0]    r_cnt;
    logic          r_err;

    logic w_accept;
    logic w_in_req;
    logic w_expire;
    logic w_enter_req;

    assign w_accept    = (r_state == c_st_idle) && start;
    assign w_in_req    = (r_state == c_st_req);
    assign w_expire    = w_in_req && !bus.mem_ack && (r_cnt == c_cnt_last);
    assign w_enter_req = (w_state_nxt == c_st_req) && !w_in_req;

    // Ack has priority over expiry, so an ack in the final REQ cycle completes normally.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (start) w_state_nxt = cmd_we ? c_st_fetch : c_st_req;
            c_st_fetch: w_state_nxt = c_st_latch;
            c_st_latch: w_state_nxt = c_st_req;
            c_st_req: begin
                if (bus.mem_ack)   w_state_nxt = r_we ? c_st_done : c_st_store;
                else if (w_expire) w_state_nxt = c_st_done;
            end
            c_st_store: w_state_nxt = c_st_done;
            c_st_done:  w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we   <= 1'b0;
            r_slot <= 2'd0;
            r_addr <= '0;
        end else if (w_accept) begin
            r_we   <= cmd_we;
            r_slot <= cmd_slot;
            r_addr <= cmd_addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdata <= 72'd0;
            r_rdata <= 72'd0;
        end else begin
            if (r_state == c_st_latch) r_wdata <= bus.x_rdata;
            if (w_in_req && bus.mem_ack && !r_we) r_rdata <= bus.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 8'd0;
        end else if (w_enter_req) begin
            r_cnt <= 8'd0;
        end else if (w_in_req && !bus.mem_ack) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Sticky error: cleared only when a new command is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_expire) begin
            r_err <= 1'b1;
        end
    end

    assign busy = (r_state != c_st_idle);
    assign done = (r_state == c_st_done);
    assign err  = r_err;

    assign bus.x_en    = (r_state == c_st_fetch) || (r_state == c_st_store);
    assign bus.x_we    = (r_state == c_st_store);
    assign bus.x_addr  = bus.x_en ? r_slot : 2'd0;
    assign bus.x_wdata = (r_state == c_st_store) ? r_rdata : 72'd0;

    assign bus.mem_req   = w_in_req;
    assign bus.mem_we    = w_in_req && r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_extbus_xseq.sv
// ============================================================================
// Module      : tb_extbus_xseq
// Description : Directed self-checking bench for extbus_xseq with a 4-slot
//               bus-file model on the X port and a hand-driven memory side.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_extbus_xseq;

    localparam int AW = 20;
    localparam int TO = 4;

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b0;
    logic          start    = 1'b0;
    logic          cmd_we   = 1'b0;
    logic [1:0]    cmd_slot = 2'd0;
    logic [AW-1:0] cmd_addr = '0;
    logic          busy;
    logic          done;
    logic          err;

    extbus_xseq_if #(.AW(AW)) bus ();

    extbus_xseq #(.AW(AW), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .cmd_we   (cmd_we),
        .cmd_slot (cmd_slot),
        .cmd_addr (cmd_addr),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Bus-file model: registered read data, write on x_en & x_we.
    logic [71:0] rf [4];
    logic [71:0] rf_q = 72'd0;
    int          wr_cnt = 0;
    logic        pl_en = 1'b0;
    logic [1:0]  pl_slot = 2'd0;
    logic [71:0] pl_data = 72'd0;

    always @(posedge clk) begin
        if (pl_en) begin
            rf[pl_slot] <= pl_data;
        end else if (bus.x_en && bus.x_we) begin
            rf[bus.x_addr] <= bus.x_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.x_en && !bus.x_we) rf_q <= rf[bus.x_addr];
    end
    assign bus.x_rdata = rf_q;

    // {busy, done, err, x_en, x_we, x_addr[1:0], mem_req, mem_we}
    logic [8:0] ctl;
    assign ctl = {busy, done, err, bus.x_en, bus.x_we, bus.x_addr, bus.mem_req, bus.mem_we};

    localparam logic [71:0] c_store_val = 72'hA5_0123456789ABCDEF;
    localparam logic [71:0] c_load_val  = 72'h3C_FEDCBA9876543210;
    localparam logic [71:0] c_keep_val  = 72'h77_1122334455667788;
    localparam logic [71:0] c_bnd_val   = 72'hC3_0F0F0F0F0F0F0F0F;
    localparam logic [71:0] c_abuse_val = 72'h5A_DEADBEEFCAFEF00D;
    localparam logic [71:0] c_late_val  = 72'hEE_EEEEEEEEEEEEEEEE;
    localparam logic [71:0] c_new_val   = 72'h9D_0011223344556677;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic preload(input logic [1:0] s, input logic [71:0] d);
        pl_slot = s;
        pl_data = d;
        pl_en   = 1'b1;
        cyc();
        pl_en   = 1'b0;
    endtask

    // Presents a command for one edge; returns at the negedge of cycle 1.
    task automatic issue(input logic we, input logic [1:0] s, input logic [AW-1:0] a);
        start    = 1'b1;
        cmd_we   = we;
        cmd_slot = s;
        cmd_addr = a;
        cyc();
        start    = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] e;
        reset_n = 1'b0;
        repeat (2) cyc();
        e = 9'b0;
        total++;
        if (ctl !== e) begin bad++; $display("FAIL reset_ctl: got %b want %b", ctl, e); end
        total++;
        if ({bus.mem_addr, bus.mem_wdata, bus.x_wdata} !== '0) begin
            bad++;
            $display("FAIL reset_data: mem_addr=%h mem_wdata=%h x_wdata=%h want 0",
                     bus.mem_addr, bus.mem_wdata, bus.x_wdata);
        end
        reset_n = 1'b1;
        cyc();
        total++;
        if (ctl !== e) begin bad++; $display("FAIL reset_idle: got %b want %b", ctl, e); end
    endtask

    task automatic test_store();
        logic [8:0] e;
        preload(2'd2, c_store_val);
        issue(1'b1, 2'd2, 20'h00400);
        e = 9'b1_0_0_1_0_10_0_0;
        total++;
        if (ctl !== e) begin bad++; $display("FAIL store_fetch: got %b want %b", ctl, e); end
        cyc();
        e = 9'b1_0_0_0_0_00_0_0;
        total++;
        if (ctl !== e) begin bad++; $display("FAIL store_latch: got %b want %b", ctl, e); end
        cyc();
        e = 9'b1_0_0_0_0_00_1_1;
        total++;
        if (ctl !== e) begin bad++; $display("FAIL store_req: got %b want %b", ctl, e); end
        total++;
        if (bus.mem_addr !== 20'h00400) begin
            bad++; $display("FAIL store_addr: got %h want 00400", bus.mem_addr);
        end
        total++;
        if (bus.mem_wdata !== c_store_val) begin
            bad++; $display("FAIL store_wdata: got %h want %h", bus.mem_wdata, c_store_val);
        end
        total++;
        if (bus.x_wdata !== 72'd0) begin
            bad++; $display("FAIL store_xwdata_idle: got %h want 0", bus.x_wdata);
        end
        bus.mem_ack = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        e = 9'b1_1_0_0_0_00_0_0;
        total++;
        if (ctl !== e) begin bad++; $display("FAIL store_done: got %b want %b", ctl, e); end
        cyc();
        total++;
        if (ctl !== 9'b0 || bus.mem_addr !== 20'h00400) begin
            bad++; $display("FAIL store_after: ctl=%b mem_addr=%h want 0/00400", ctl, bus.mem_addr);
        end
    endtask

    task automatic test_load();
        logic [8:0] e;
        int w0;
        w0 = wr_cnt;
        issue(1'b0, 2'd1, 20'h00123);
        e = 9'b1_0_0_0_0_00_1_0;
        total++;
        if (ctl !== e || bus.mem_addr !== 20'h00123) begin
            bad++; $display("FAIL load_req1: ctl=%b addr=%h want %b/00123", ctl, bus.mem_addr, e);
        end
        cyc();
        total++;
        if (ctl !== e) begin bad++; $display("FAIL load_req2: got %b want %b", ctl, e); end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = c_load_val;
        cyc();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 72'd0;
        e = 9'b1_0_0_1_1_01_0_0;
        total++;
        if (ctl !== e) begin bad++; $display("FAIL load_store: got %b want %b", ctl, e); end
        total++;
        if (bus.x_wdata !== c_load_val) begin
            bad++; $display("FAIL load_xwdata: got %h want %h", bus.x_wdata, c_load_val);
        end
        cyc();
        e = 9'b1_1_0_0_0_00_0_0;
        total++;
        if (ctl !== e) begin bad++; $display("FAIL load_done: got %b want %b", ctl, e); end
        total++;
        if (rf[1] !== c_load_val || wr_cnt !== w0 + 1) begin
            bad++; $display("FAIL load_slot: slot1=%h writes=%0d want %h/%0d", rf[1], wr_cnt - w0, c_load_val, 1);
        end
        cyc();
    endtask

    task automatic test_readback();
        issue(1'b1, 2'd1, 20'h00005);
        cyc();
        cyc();
        total++;
        if (!bus.mem_req || bus.mem_wdata !== c_load_val) begin
            bad++; $display("FAIL readback: req=%b wdata=%h want 1/%h", bus.mem_req, bus.mem_wdata, c_load_val);
        end
        bus.mem_ack = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL readback_done: got %b want 1", done); end
        cyc();
    endtask

    task automatic test_timeout();
        int w0;
        int nreq;
        bit seen;
        preload(2'd3, c_keep_val);
        w0   = wr_cnt;
        nreq = 0;
        seen = 1'b0;
        issue(1'b0, 2'd3, 20'h0ABCD);
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.mem_req) nreq++;
            if (done) begin
                seen = 1'b1;
                total++;
                if (err !== 1'b1) begin bad++; $display("FAIL timeout_err: got %b want 1", err); end
            end else begin
                cyc();
            end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL timeout_bound: done never seen, want done"); end
        total++;
        if (nreq !== TO) begin bad++; $display("FAIL timeout_reqcycles: got %0d want %0d", nreq, TO); end
        total++;
        if (rf[3] !== c_keep_val || wr_cnt !== w0) begin
            bad++; $display("FAIL timeout_slot: slot3=%h writes=%0d want %h/0", rf[3], wr_cnt - w0, c_keep_val);
        end
        cyc();
        total++;
        if (ctl !== 9'b0_0_1_0_0_00_0_0) begin
            bad++; $display("FAIL timeout_sticky: got %b want 001000000", ctl);
        end
    endtask

    task automatic test_ack_boundary();
        logic [8:0] e;
        issue(1'b0, 2'd0, 20'h00077);
        e = 9'b1_0_0_0_0_00_1_0;
        total++;
        if (ctl !== e) begin bad++; $display("FAIL bnd_errclr: got %b want %b", ctl, e); end
        repeat (3) cyc();
        total++;
        if (ctl !== e) begin bad++; $display("FAIL bnd_req4: got %b want %b", ctl, e); end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = c_bnd_val;
        cyc();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 72'd0;
        e = 9'b1_0_0_1_1_00_0_0;
        total++;
        if (ctl !== e || bus.x_wdata !== c_bnd_val) begin
            bad++; $display("FAIL bnd_store: ctl=%b xw=%h want %b/%h", ctl, bus.x_wdata, e, c_bnd_val);
        end
        cyc();
        e = 9'b1_1_0_0_0_00_0_0;
        total++;
        if (ctl !== e) begin bad++; $display("FAIL bnd_done: got %b want %b", ctl, e); end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [8:0] e;
        int ndone;
        int w0;
        ndone = 0;
        issue(1'b0, 2'd2, 20'h00200);
        start    = 1'b1;
        cmd_we   = 1'b1;
        cmd_slot = 2'd3;
        cmd_addr = 20'hFFFFF;
        cyc();
        start = 1'b0;
        e = 9'b1_0_0_0_0_00_1_0;
        total++;
        if (ctl !== e || bus.mem_addr !== 20'h00200) begin
            bad++; $display("FAIL abuse_req: ctl=%b addr=%h want %b/00200", ctl, bus.mem_addr, e);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = c_abuse_val;
        cyc();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 72'd0;
        e = 9'b1_0_0_1_1_10_0_0;
        total++;
        if (ctl !== e) begin bad++; $display("FAIL abuse_store: got %b want %b", ctl, e); end
        cyc();
        if (done) ndone++;
        start    = 1'b1;
        cmd_we   = 1'b1;
        cmd_slot = 2'd2;
        cmd_addr = 20'h00300;
        cyc();
        if (done) ndone++;
        total++;
        if (ctl !== 9'b0) begin bad++; $display("FAIL abuse_done_start: got %b want 000000000", ctl); end
        cyc();
        start = 1'b0;
        e = 9'b1_0_0_1_0_10_0_0;
        total++;
        if (ctl !== e) begin bad++; $display("FAIL after_done_accept: got %b want %b", ctl, e); end
        cyc();
        cyc();
        total++;
        if (!bus.mem_req || bus.mem_addr !== 20'h00300 || bus.mem_wdata !== c_abuse_val) begin
            bad++; $display("FAIL after_done_req: req=%b addr=%h wd=%h want 1/00300/%h",
                            bus.mem_req, bus.mem_addr, bus.mem_wdata, c_abuse_val);
        end
        bus.mem_ack = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        if (done) ndone++;
        cyc();
        if (done) ndone++;
        total++;
        if (ndone !== 2) begin bad++; $display("FAIL abuse_done_count: got %0d want 2", ndone); end
        // Spurious ack while idle.
        w0 = wr_cnt;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = {72{1'b1}};
        cyc();
        cyc();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 72'd0;
        total++;
        if (ctl !== 9'b0 || wr_cnt !== w0 || bus.mem_addr !== 20'h00300) begin
            bad++; $display("FAIL idle_ack: ctl=%b writes=%0d addr=%h want 0/0/00300", ctl, wr_cnt - w0, bus.mem_addr);
        end
    endtask

    task automatic test_reset_mid_req();
        logic [8:0] e;
        int w0;
        w0 = wr_cnt;
        issue(1'b0, 2'd1, 20'h00456);
        total++;
        if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL rst_pre_req: got %b want 1", bus.mem_req); end
        reset_n = 1'b0;
        #1;
        total++;
        if (ctl !== 9'b0 || {bus.mem_addr, bus.mem_wdata, bus.x_wdata} !== '0) begin
            bad++; $display("FAIL rst_immediate: ctl=%b addr=%h wd=%h want all 0", ctl, bus.mem_addr, bus.mem_wdata);
        end
        cyc();
        reset_n       = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = c_late_val;
        cyc();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 72'd0;
        total++;
        if (ctl !== 9'b0 || wr_cnt !== w0 || rf[1] !== c_load_val) begin
            bad++; $display("FAIL rst_late_ack: ctl=%b writes=%0d slot1=%h want 0/0/%h", ctl, wr_cnt - w0, rf[1], c_load_val);
        end
        issue(1'b0, 2'd1, 20'h00457);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = c_new_val;
        cyc();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 72'd0;
        e = 9'b1_0_0_1_1_01_0_0;
        total++;
        if (ctl !== e) begin bad++; $display("FAIL rst_new_store: got %b want %b", ctl, e); end
        cyc();
        e = 9'b1_1_0_0_0_00_0_0;
        total++;
        if (ctl !== e || rf[1] !== c_new_val) begin
            bad++; $display("FAIL rst_new_done: ctl=%b slot1=%h want %b/%h", ctl, rf[1], e, c_new_val);
        end
        cyc();
    endtask

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 72'd0;
        cyc();
        test_reset();
        test_store();
        test_load();
        test_readback();
        test_timeout();
        test_ack_boundary();
        test_back_to_back();
        test_reset_mid_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/extbus_xseq.md
# extbus_xseq

X-port transfer sequencer for the external bus register file. Moves one 72-bit word (64 data + 8 tag) between a selected register-file slot and external memory, using a request/acknowledge handshake with a bounded wait. It sits on the memory side of the four-port bus file and drives that file's X port. Port A is left to the CPU datapath, and ports B and C are left to their existing users.

## Interface

- AW, 20: memory word address width.
- TIMEOUT, 255: maximum REQ cycles before abort, 1..255.

- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- cmd_we  in  1  1 = store (slot -> memory), 0 = load (memory -> slot).
- cmd_slot  in  2  register-file slot, 0..3.
- cmd_addr  in  AW  memory word address.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  last command timed out; sticky until the next accepted start.
- x_addr  out  2  X port address (AX).
- x_en  out  1  X port enable (ECX).
- x_we  out  1  X port write enable (WX).
- x_wdata  out  72  X port write data (DX).
- x_rdata  in  72  X port read data (oDX); valid the cycle after x_en=1 with x_we=0.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  AW  memory address.
- mem_wdata  out  72  memory write data.
- mem_rdata  in  72  memory read data; valid with mem_ack.
- mem_ack  in  1  memory acknowledge; single-cycle pulse.

## Operation

- States: IDLE, FETCH, LATCH, REQ, STORE, DONE. Moore outputs are decoded from the state register plus the command registers.
- IDLE: start=1 latches cmd_we, cmd_slot and cmd_addr, and clears err.
  - Store command -> FETCH.
  - Load command -> REQ.
- FETCH: x_en=1, x_we=0, x_addr=slot. Unconditionally -> LATCH.
- LATCH: x_rdata is captured into the mem_wdata register at the edge. -> REQ.
- REQ:
  - Drives mem_req=1, mem_we=cmd_we and mem_addr=latched address, all stable for the whole state.
  - Wait counter is cleared on entry and increments on each edge without mem_ack.
  - mem_ack=1 at an edge:
    - load: captures mem_rdata -> STORE.
    - store: -> DONE.
  - No ack with counter == TIMEOUT-1: sets err -> DONE, and the slot is not written.
- STORE: x_en=1, x_we=1, x_addr=slot, x_wdata=captured mem_rdata. -> DONE.
- DONE: done=1 and busy=1. -> IDLE.
- Outside their states, x_en, x_we, mem_req and done are 0.
- mem_addr and mem_wdata hold their last values.
- x_wdata is 0 except in STORE.
- The tag field (bits 71:64) is carried unmodified in both directions.

## Timing

- Reset: state=IDLE; all outputs 0; counter 0; mem_addr, mem_wdata and the captured read data are 0.
- Reset asserted mid-command aborts immediately: no further X write and no mem_req. A memory cycle in flight is abandoned, and a late mem_ack is ignored.
- Store latency (start sampled at edge E0, ack in first REQ cycle):
  - FETCH in cycle 1, LATCH in cycle 2, REQ in cycle 3.
  - Ack is sampled at E3, and done is high in cycle 4.
  - Each extra wait cycle adds 1.
- Load latency: REQ in cycle 1, ack at E1, STORE in cycle 2, done in cycle 3.
- Timeout: REQ lasts exactly TIMEOUT cycles. If ack arrives in the last REQ cycle, ack wins and err stays 0.
- start while busy (including the DONE cycle) is ignored and does not queue. A start in the cycle after DONE is accepted.
- mem_ack outside REQ is ignored.
- err updates only at start acceptance (clear) and at timeout (set).

## Test plan

- Store: preload slot 2 = 72'hA5_0123456789ABCDEF, then start cmd_we=1 cmd_slot=2 cmd_addr=20'h00400.
  - Expect mem_req with mem_addr=20'h00400 and mem_wdata=72'hA5_0123456789ABCDEF in cycle 3.
  - Ack in the same cycle -> done in cycle 4, err=0.
- Load: start cmd_we=0 cmd_slot=1; ack in cycle 2 with mem_rdata=72'h3C_FEDCBA9876543210.
  - Expect an X write to slot 1 of that value in cycle 3 and done in cycle 4.
  - A subsequent port read returns the value.
- Timeout: TIMEOUT=4, load with no ack.
  - Expect exactly 4 mem_req cycles, then done with err=1 and slot contents unchanged.
  - The next accepted start clears err.
- Ack at boundary: TIMEOUT=4, ack in the 4th REQ cycle -> normal completion, err=0.
- Protocol abuse:
  - start pulsed during REQ and during DONE -> ignored, exactly one done.
  - Spurious mem_ack while in IDLE -> no effect.
- Reset mid-REQ: deassert reset_n for 1 cycle during REQ.
  - Expect all outputs 0 immediately and no slot write.
  - A late ack is ignored, and a new command then completes normally.
